// File: rtl/hazard_stall_unit.sv
// Load-use / ID-branch hazard stall and data-memory freeze control for the uDLX pipeline.
// Optional statistics counters are built when HAZARD_STALL_STATS_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned MEM_TIMEOUT    = 255,
    parameter int unsigned CNT_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    input  logic                      id_is_branch,
    input  logic [REG_ADDR_WIDTH-1:0] ex_dst_addr,
    input  logic                      ex_wr_ena,
    input  logic                      ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] mem_dst_addr,
    input  logic                      mem_wr_ena,
    input  logic                      mem_is_load,
    input  logic                      mem_req,
    input  logic                      mem_ack,
    output logic                      pc_wr_ena,
    output logic                      if_id_wr_ena,
    output logic                      id_ex_bubble,
    output logic                      id_ex_wr_ena,
    output logic                      ex_mem_wr_ena,
    output logic                      mem_wb_wr_ena,
    output logic                      stall_active,
    output logic                      mem_timeout_err
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               bubble_count,
    output logic [31:0]               freeze_cycles
`endif
);

    localparam int unsigned WCNT_WIDTH = 16;
    localparam logic [WCNT_WIDTH-1:0] TimeoutVal = WCNT_WIDTH'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StStall, StMemWait} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;
    logic                  err_q, err_d;

    logic       match_ex, match_mem;
    logic       freeze;
    logic [1:0] need_n;
    logic       do_stall, do_freeze;

    // Register 0 is hardwired zero, so a write to it never creates a dependency.
    assign match_ex  = ex_wr_ena & (ex_dst_addr != '0) &
                       ((id_rs_used & (id_rs_addr == ex_dst_addr)) |
                        (id_rt_used & (id_rt_addr == ex_dst_addr)));
    assign match_mem = mem_wr_ena & (mem_dst_addr != '0) &
                       ((id_rs_used & (id_rs_addr == mem_dst_addr)) |
                        (id_rt_used & (id_rt_addr == mem_dst_addr)));

    assign freeze = mem_req & ~mem_ack;

    always_comb begin
        need_n = 2'd0;
        if (id_is_branch & ex_is_load & match_ex) begin
            need_n = 2'd2;
        end else if (ex_is_load & match_ex) begin
            need_n = 2'd1;
        end else if (id_is_branch & match_ex) begin
            need_n = 2'd1;
        end else if (id_is_branch & mem_is_load & match_mem) begin
            need_n = 2'd1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        unique case (state_q)
            StRun: begin
                if (freeze) begin
                    state_d = StMemWait;
                end else if (need_n != 2'd0) begin
                    cnt_d   = CNT_WIDTH'(need_n - 2'd1);
                    state_d = (need_n > 2'd1) ? StStall : StRun;
                end
            end
            StStall: begin
                if (freeze) begin
                    state_d = StMemWait;
                end else begin
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                    state_d = (cnt_d == '0) ? StRun : StStall;
                end
            end
            StMemWait: begin
                if (mem_ack) begin
                    wcnt_d  = '0;
                    state_d = (cnt_q != '0) ? StStall : StRun;
                end else begin
                    if (wcnt_q != '1) begin
                        wcnt_d = wcnt_q + WCNT_WIDTH'(1);
                    end
                    if (wcnt_d >= TimeoutVal) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Output logic (Mealy on freeze/hazard inputs)
    always_comb begin
        do_stall  = 1'b0;
        do_freeze = 1'b0;
        unique case (state_q)
            StRun: begin
                if (freeze) begin
                    do_freeze = 1'b1;
                end else if (need_n != 2'd0) begin
                    do_stall = 1'b1;
                end
            end
            StStall: begin
                if (freeze) begin
                    do_freeze = 1'b1;
                end else begin
                    do_stall = 1'b1;
                end
            end
            StMemWait: begin
                if (!mem_ack) begin
                    do_freeze = 1'b1;
                end else if (cnt_q != '0) begin
                    do_stall = 1'b1;
                end
            end
            default: do_freeze = 1'b1;
        endcase

        if (rst) begin
            pc_wr_ena     = 1'b0;
            if_id_wr_ena  = 1'b0;
            id_ex_bubble  = 1'b1;
            id_ex_wr_ena  = 1'b0;
            ex_mem_wr_ena = 1'b0;
            mem_wb_wr_ena = 1'b0;
        end else begin
            pc_wr_ena     = ~(do_stall | do_freeze);
            if_id_wr_ena  = ~(do_stall | do_freeze);
            id_ex_bubble  = do_stall;
            id_ex_wr_ena  = ~do_freeze;
            ex_mem_wr_ena = ~do_freeze;
            mem_wb_wr_ena = ~do_freeze;
        end
        stall_active = ~pc_wr_ena;
    end

    assign mem_timeout_err = err_q;

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cycles_q, bubble_count_q, freeze_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q  <= '0;
            bubble_count_q  <= '0;
            freeze_cycles_q <= '0;
        end else begin
            if (stall_active) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (id_ex_bubble) bubble_count_q <= bubble_count_q + 32'd1;
            if (state_q == StMemWait) freeze_cycles_q <= freeze_cycles_q + 32'd1;
        end
    end

    assign stall_cycles  = stall_cycles_q;
    assign bubble_count  = bubble_count_q;
    assign freeze_cycles = freeze_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: directed test-plan sequences followed by random stimulus, all
// compared against a cycle-level behavioural model of owed stalls and memory waits.
module tb_hazard_stall_unit;

    localparam int unsigned Timeout = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr, ex_dst_addr, mem_dst_addr;
    logic       id_rs_used, id_rt_used, id_is_branch;
    logic       ex_wr_ena, ex_is_load, mem_wr_ena, mem_is_load, mem_req, mem_ack;
    logic       pc_wr_ena, if_id_wr_ena, id_ex_bubble, id_ex_wr_ena;
    logic       ex_mem_wr_ena, mem_wb_wr_ena, stall_active, mem_timeout_err;
`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] stall_cycles, bubble_count, freeze_cycles;
    int unsigned m_stalls, m_bubbles, m_freezes;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: stall cycles still owed, waiting-on-memory flag, wait length, sticky error.
    int m_rem;
    bit m_wait;
    int m_wcnt;
    bit m_err;

    hazard_stall_unit #(
        .REG_ADDR_WIDTH(5),
        .MEM_TIMEOUT   (Timeout),
        .CNT_WIDTH     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .id_is_branch   (id_is_branch),
        .ex_dst_addr    (ex_dst_addr),
        .ex_wr_ena      (ex_wr_ena),
        .ex_is_load     (ex_is_load),
        .mem_dst_addr   (mem_dst_addr),
        .mem_wr_ena     (mem_wr_ena),
        .mem_is_load    (mem_is_load),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .pc_wr_ena      (pc_wr_ena),
        .if_id_wr_ena   (if_id_wr_ena),
        .id_ex_bubble   (id_ex_bubble),
        .id_ex_wr_ena   (id_ex_wr_ena),
        .ex_mem_wr_ena  (ex_mem_wr_ena),
        .mem_wb_wr_ena  (mem_wb_wr_ena),
        .stall_active   (stall_active),
        .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_STALL_STATS_EN
        ,
        .stall_cycles   (stall_cycles),
        .bubble_count   (bubble_count),
        .freeze_cycles  (freeze_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] dst, input bit wr);
        return wr && (dst != 0) &&
               ((id_rs_used && id_rs_addr == dst) || (id_rt_used && id_rt_addr == dst));
    endfunction

    function automatic int need();
        bit mex = reads(ex_dst_addr, ex_wr_ena);
        bit mmem = reads(mem_dst_addr, mem_wr_ena);
        if (id_is_branch && ex_is_load && mex) return 2;
        if (ex_is_load && mex) return 1;
        if (id_is_branch && mex) return 1;
        if (id_is_branch && mem_is_load && mmem) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        {id_rs_addr, id_rt_addr, ex_dst_addr, mem_dst_addr} = '0;
        {id_rs_used, id_rt_used, id_is_branch, ex_wr_ena, ex_is_load} = '0;
        {mem_wr_ena, mem_is_load, mem_req, mem_ack} = '0;
    endtask

    // Called at a falling edge with inputs already set; checks, advances model, next negedge.
    task automatic tick();
        int mode = 0; // 0 normal, 1 stall, 2 frozen, 3 reset
        int n = 0;
        logic [6:0] exp_ctl, obs_ctl;
        #1;
        if (rst) mode = 3;
        else if (m_wait) mode = mem_ack ? ((m_rem > 0) ? 1 : 0) : 2;
        else if (mem_req && !mem_ack) mode = 2;
        else if (m_rem > 0) mode = 1;
        else begin
            n = need();
            mode = (n > 0) ? 1 : 0;
        end
        case (mode)
            0: exp_ctl = 7'b1101110;
            1: exp_ctl = 7'b0011111;
            2: exp_ctl = 7'b0000001;
            default: exp_ctl = 7'b0010001;
        endcase
        obs_ctl = {pc_wr_ena, if_id_wr_ena, id_ex_bubble, id_ex_wr_ena,
                   ex_mem_wr_ena, mem_wb_wr_ena, stall_active};
        check("ctl", 32'(obs_ctl), 32'(exp_ctl));
        check("err", 32'(mem_timeout_err), 32'(m_err));
`ifdef HAZARD_STALL_STATS_EN
        check("stall_cycles", stall_cycles, m_stalls);
        check("bubble_count", bubble_count, m_bubbles);
        check("freeze_cycles", freeze_cycles, m_freezes);
        if (rst) begin
            m_stalls = 0; m_bubbles = 0; m_freezes = 0;
        end else begin
            if (mode != 0) m_stalls++;
            if (mode == 1) m_bubbles++;
            if (m_wait) m_freezes++;
        end
`endif
        if (rst) begin
            m_rem = 0; m_wait = 0; m_wcnt = 0; m_err = 0;
        end else if (m_wait) begin
            if (mem_ack) begin
                m_wcnt = 0;
                m_wait = 0;
            end else begin
                if (m_wcnt < 65535) m_wcnt++;
                if (m_wcnt >= Timeout) m_err = 1;
            end
        end else if (mem_req && !mem_ack) begin
            m_wait = 1;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (n > 0) begin
            m_rem = n - 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_use(input bit branch);
        clear_inputs();
        ex_is_load = 1; ex_wr_ena = 1; ex_dst_addr = 5'd3;
        id_rs_addr = 5'd3; id_rs_used = 1; id_is_branch = branch;
    endtask

    initial begin
        m_rem = 0; m_wait = 0; m_wcnt = 0; m_err = 0;
`ifdef HAZARD_STALL_STATS_EN
        m_stalls = 0; m_bubbles = 0; m_freezes = 0;
`endif
        clear_inputs();
        rst = 1;
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        tick();

        // Load-use: one bubble, then back to normal
        load_use(0); tick();
        clear_inputs(); tick();

        // Branch on load: two stall cycles
        load_use(1); tick(); tick();
        clear_inputs(); tick();

        // r0 never creates a hazard
        clear_inputs();
        ex_is_load = 1; ex_wr_ena = 1; id_rs_used = 1; tick();
        clear_inputs();
        id_is_branch = 1; mem_wr_ena = 1; mem_is_load = 1; id_rt_used = 1; tick();

        // Memory wait arriving in the STALL cycle
        load_use(1); tick();
        clear_inputs(); mem_req = 1;
        repeat (3) tick();
        mem_ack = 1; tick();
        clear_inputs(); tick(); tick();

        // Timeout flag and its stickiness
        clear_inputs(); mem_req = 1;
        repeat (6) tick();
        mem_ack = 1; tick();
        clear_inputs(); tick(); tick();

        // Reset in the middle of a memory wait
        mem_req = 1; tick(); tick();
        rst = 1; tick();
        rst = 0; clear_inputs(); tick(); tick();

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 149) == 0);
            id_rs_addr   = 5'($urandom_range(0, 3));
            id_rt_addr   = 5'($urandom_range(0, 3));
            ex_dst_addr  = 5'($urandom_range(0, 3));
            mem_dst_addr = 5'($urandom_range(0, 3));
            id_rs_used   = 1'($urandom_range(0, 1));
            id_rt_used   = 1'($urandom_range(0, 1));
            id_is_branch = 1'($urandom_range(0, 1));
            ex_wr_ena    = 1'($urandom_range(0, 1));
            ex_is_load   = 1'($urandom_range(0, 1));
            mem_wr_ena   = 1'($urandom_range(0, 1));
            mem_is_load  = 1'($urandom_range(0, 1));
            if (m_wait) begin
                mem_req = 1;
                mem_ack = ($urandom_range(0, 3) == 0);
            end else begin
                mem_req = ($urandom_range(0, 5) == 0);
                mem_ack = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
